// File: rtl/pipe_sequencer.sv
// Run/stall/flush sequencer for the 5-stage pipeline with stage-valid tracking and counters.
// Define STALL_STATS_EN to add the stall_cnt/flush_cnt statistic outputs.
module pipe_sequencer #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             halt_fetched,
   input  logic             load_use,
   input  logic             br_taken_ex,
   input  logic             jump_id,
   output logic             pc_wr,
   output logic             if_id_wr,
   output logic             if_id_flush,
   output logic             id_ex_bubble,
   output logic [1:0]       state,
   output logic             done,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] retire_cnt
`ifdef STALL_STATS_EN
   ,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
`endif
);

   typedef enum logic [1:0] {
      StIdle   = 2'b00,
      StRun    = 2'b01,
      StDrain  = 2'b10,
      StHalted = 2'b11
   } state_e;

   localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

   state_e           state_q, state_d;
   // valid_q bit order: [3] ID, [2] EX, [1] MEM, [0] WB
   logic [3:0]       valid_q, valid_d;
   logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
   logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;
   logic             active;
   logic             clear_cnt;
   logic             redirect;
   logic             stall;
   logic             id_valid_next;

   always_comb begin
      state_d      = state_q;
      pc_wr        = 1'b0;
      if_id_wr     = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
      redirect     = 1'b0;
      stall        = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) state_d = StRun;
         end
         StRun: begin
            if (br_taken_ex) begin
               pc_wr        = 1'b1;
               if_id_wr     = 1'b1;
               if_id_flush  = 1'b1;
               id_ex_bubble = 1'b1;
               redirect     = 1'b1;
            end else if (jump_id) begin
               pc_wr       = 1'b1;
               if_id_wr    = 1'b1;
               if_id_flush = 1'b1;
               redirect    = 1'b1;
            end else if (load_use) begin
               id_ex_bubble = 1'b1;
               stall        = 1'b1;
            end else if (halt_fetched) begin
               // Halt is squashed in IF/ID and the PC stays parked on it.
               if_id_wr    = 1'b1;
               if_id_flush = 1'b1;
               state_d     = StDrain;
            end else begin
               pc_wr    = 1'b1;
               if_id_wr = 1'b1;
            end
         end
         StDrain: begin
            if (br_taken_ex) begin
               pc_wr        = 1'b1;
               if_id_wr     = 1'b1;
               if_id_flush  = 1'b1;
               id_ex_bubble = 1'b1;
               redirect     = 1'b1;
               state_d      = StRun;
            end else begin
               if_id_wr    = 1'b1;
               if_id_flush = 1'b1;
               if (valid_q == 4'b0000) state_d = StHalted;
            end
         end
         StHalted: begin
            state_d = StHalted;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign active    = (state_q == StRun) || (state_q == StDrain);
   assign clear_cnt = (state_q == StIdle) && start;
   assign done      = (state_q == StHalted);
   assign state     = state_q;

   always_comb begin
      valid_d       = valid_q;
      id_valid_next = (if_id_wr & ~if_id_flush) | (~if_id_wr & valid_q[3]);
      if (active) begin
         valid_d = {id_valid_next, valid_q[3] & ~id_ex_bubble, valid_q[2], valid_q[1]};
      end
   end

   always_comb begin
      cycle_cnt_d  = cycle_cnt_q;
      retire_cnt_d = retire_cnt_q;
      if (clear_cnt) begin
         cycle_cnt_d  = '0;
         retire_cnt_d = '0;
      end else if (active) begin
         if (cycle_cnt_q != CntMax) cycle_cnt_d = cycle_cnt_q + CntOne;
         if (valid_q[0] && (retire_cnt_q != CntMax)) retire_cnt_d = retire_cnt_q + CntOne;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         valid_q      <= 4'b0000;
         cycle_cnt_q  <= '0;
         retire_cnt_q <= '0;
      end else begin
         state_q      <= state_d;
         valid_q      <= valid_d;
         cycle_cnt_q  <= cycle_cnt_d;
         retire_cnt_q <= retire_cnt_d;
      end
   end

   assign cycle_cnt  = cycle_cnt_q;
   assign retire_cnt = retire_cnt_q;

`ifdef STALL_STATS_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (clear_cnt) begin
         stall_cnt_d = '0;
         flush_cnt_d = '0;
      end else begin
         if (stall && (stall_cnt_q != CntMax)) stall_cnt_d = stall_cnt_q + CntOne;
         if (redirect && (flush_cnt_q != CntMax)) flush_cnt_d = flush_cnt_q + CntOne;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_sequencer.sv
// Self-checking bench for pipe_sequencer: per-cycle model comparison plus directed literal checks.
// Two instances (16-bit and 4-bit counters) share one stimulus stream.
module tb_pipe_sequencer;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic start = 1'b0, halt_fetched = 1'b0, load_use = 1'b0, br_taken_ex = 1'b0, jump_id = 1'b0;

   logic        pc_wr, if_id_wr, if_id_flush, id_ex_bubble, done;
   logic [1:0]  state;
   logic [15:0] cycle_cnt, retire_cnt;
   logic        pc_wr4, if_id_wr4, if_id_flush4, id_ex_bubble4, done4;
   logic [1:0]  state4;
   logic [3:0]  cycle_cnt4, retire_cnt4;
`ifdef STALL_STATS_EN
   logic [15:0] stall_cnt, flush_cnt;
   logic [3:0]  stall_cnt4, flush_cnt4;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pipe_sequencer #(.CNT_W(16)) u_dut (
      .clk(clk), .rst(rst), .start(start), .halt_fetched(halt_fetched), .load_use(load_use),
      .br_taken_ex(br_taken_ex), .jump_id(jump_id), .pc_wr(pc_wr), .if_id_wr(if_id_wr),
      .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble), .state(state), .done(done),
      .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt)
`ifdef STALL_STATS_EN
      , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
   );

   pipe_sequencer #(.CNT_W(4)) u_dut4 (
      .clk(clk), .rst(rst), .start(start), .halt_fetched(halt_fetched), .load_use(load_use),
      .br_taken_ex(br_taken_ex), .jump_id(jump_id), .pc_wr(pc_wr4), .if_id_wr(if_id_wr4),
      .if_id_flush(if_id_flush4), .id_ex_bubble(id_ex_bubble4), .state(state4), .done(done4),
      .cycle_cnt(cycle_cnt4), .retire_cnt(retire_cnt4)
`ifdef STALL_STATS_EN
      , .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: decision table {pc_wr, if_id_wr, flush, bubble, next_state}
   function automatic logic [5:0] decide(input logic [1:0] st, input logic s, input logic h,
                                         input logic lu, input logic br, input logic j,
                                         input logic any_v);
      case (st)
         2'd0: return {4'b0000, (s ? 2'd1 : 2'd0)};
         2'd1: begin
            if (br) return {4'b1111, 2'd1};
            if (j) return {4'b1110, 2'd1};
            if (lu) return {4'b0001, 2'd1};
            if (h) return {4'b0110, 2'd2};
            return {4'b1100, 2'd1};
         end
         2'd2: begin
            if (br) return {4'b1111, 2'd1};
            return {4'b0110, (any_v ? 2'd2 : 2'd3)};
         end
         default: return {4'b0000, 2'd3};
      endcase
   endfunction

   function automatic int sat(input int v, input int w);
      int mx;
      mx = (1 << w) - 1;
      return (v > mx) ? mx : v;
   endfunction

   logic [1:0] m_state = 2'd0;
   logic m_id = 1'b0, m_ex = 1'b0, m_mem = 1'b0, m_wb = 1'b0;
   int m_cyc = 0, m_ret = 0, m_stall = 0, m_flush = 0;

   always @(posedge clk or posedge rst) begin
      logic [5:0] d;
      if (rst) begin
         m_state <= 2'd0;
         {m_id, m_ex, m_mem, m_wb} <= 4'b0000;
         m_cyc <= 0; m_ret <= 0; m_stall <= 0; m_flush <= 0;
      end else begin
         d = decide(m_state, start, halt_fetched, load_use, br_taken_ex, jump_id,
                    m_id | m_ex | m_mem | m_wb);
         if (m_state == 2'd0 && start) begin
            m_cyc <= 0; m_ret <= 0; m_stall <= 0; m_flush <= 0;
         end
         if (m_state == 2'd1 || m_state == 2'd2) begin
            m_cyc <= m_cyc + 1;
            if (m_wb) m_ret <= m_ret + 1;
            m_id  <= (d[4] & ~d[3]) | (~d[4] & m_id);
            m_ex  <= m_id & ~d[2];
            m_mem <= m_ex;
            m_wb  <= m_mem;
            if (m_state == 2'd1 && !br_taken_ex && !jump_id && load_use) m_stall <= m_stall + 1;
            if ((m_state == 2'd1 && (br_taken_ex || jump_id)) || (m_state == 2'd2 && br_taken_ex))
               m_flush <= m_flush + 1;
         end
         m_state <= d[1:0];
      end
   end

   always @(negedge clk) begin
      logic [5:0] d;
      if (!rst) begin
         d = decide(m_state, start, halt_fetched, load_use, br_taken_ex, jump_id,
                    m_id | m_ex | m_mem | m_wb);
         chk("ctl", {28'd0, pc_wr, if_id_wr, if_id_flush, id_ex_bubble}, {28'd0, d[5:2]});
         chk("ctl4", {28'd0, pc_wr4, if_id_wr4, if_id_flush4, id_ex_bubble4}, {28'd0, d[5:2]});
         chk("state", {30'd0, state}, {30'd0, m_state});
         chk("state4", {30'd0, state4}, {30'd0, m_state});
         chk("done", {31'd0, done}, {31'd0, (m_state == 2'd3)});
         chk("cycle_cnt", {16'd0, cycle_cnt}, sat(m_cyc, 16));
         chk("retire_cnt", {16'd0, retire_cnt}, sat(m_ret, 16));
         chk("cycle_cnt4", {28'd0, cycle_cnt4}, sat(m_cyc, 4));
         chk("retire_cnt4", {28'd0, retire_cnt4}, sat(m_ret, 4));
`ifdef STALL_STATS_EN
         chk("stall_cnt", {16'd0, stall_cnt}, sat(m_stall, 16));
         chk("flush_cnt", {16'd0, flush_cnt}, sat(m_flush, 16));
         chk("stall_cnt4", {28'd0, stall_cnt4}, sat(m_stall, 4));
         chk("flush_cnt4", {28'd0, flush_cnt4}, sat(m_flush, 4));
`endif
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic s, input logic h, input logic lu, input logic br,
                        input logic j);
      start = s; halt_fetched = h; load_use = lu; br_taken_ex = br; jump_id = j;
   endtask

   task automatic run_to_halt(input string name);
      for (int i = 0; i < 40 && state != 2'd3; i++) tick();
      chk(name, {30'd0, state}, 32'd3);
   endtask

   initial begin
      #2 rst = 1'b1;
      #21 rst = 1'b0;
      #1;
      chk("idle_state", {30'd0, state}, 32'd0);
      chk("idle_pc_wr", {31'd0, pc_wr}, 32'd0);
      chk("idle_done", {31'd0, done}, 32'd0);

      // Straight-line: start in cycle 0, plain 1..6, halt in 7
      @(posedge clk); #1;
      drive(1, 0, 0, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0);
      repeat (6) tick();
      drive(0, 1, 0, 0, 0);
      #1;
      chk("halt_pc_wr", {31'd0, pc_wr}, 32'd0);
      chk("halt_flush", {31'd0, if_id_flush}, 32'd1);
      tick();
      drive(0, 0, 0, 0, 0);
      chk("drain_c8", {30'd0, state}, 32'd2);
      repeat (3) tick();
      chk("drain_c11", {30'd0, state}, 32'd2);
      tick();
      chk("halted_c12", {30'd0, state}, 32'd3);
      chk("halted_done", {31'd0, done}, 32'd1);
      chk("sl_retire", {16'd0, retire_cnt}, 32'd6);
      chk("sl_cycle", {16'd0, cycle_cnt}, 32'd11);

      // start ignored in HALTED
      drive(1, 0, 0, 0, 0);
      tick();
      chk("halted_sticky", {30'd0, state}, 32'd3);
      drive(0, 0, 0, 0, 0);

      // Async reset then a short run, then async reset mid-RUN
      #3 rst = 1'b1;
      #1;
      chk("rst1_state", {30'd0, state}, 32'd0);
      #2 rst = 1'b0;
      tick();
      drive(1, 0, 0, 0, 0);
      tick();
      chk("restart_run", {30'd0, state}, 32'd1);
      drive(0, 0, 0, 0, 0);
      repeat (6) tick();
      #3 rst = 1'b1;
      #1;
      chk("rst_state", {30'd0, state}, 32'd0);
      chk("rst_cycle", {16'd0, cycle_cnt}, 32'd0);
      chk("rst_retire", {16'd0, retire_cnt}, 32'd0);
      chk("rst_pc_wr", {31'd0, pc_wr}, 32'd0);
      #2 rst = 1'b0;
      tick();

      // Load-use: plain 1,2; stall in 3; plain 4..7; halt in 8
      drive(1, 0, 0, 0, 0);
      tick();
      chk("lu_run", {30'd0, state}, 32'd1);
      drive(0, 0, 0, 0, 0);
      repeat (2) tick();
      drive(0, 0, 1, 0, 0);
      #1;
      chk("lu_pc_wr", {31'd0, pc_wr}, 32'd0);
      chk("lu_if_id_wr", {31'd0, if_id_wr}, 32'd0);
      chk("lu_bubble", {31'd0, id_ex_bubble}, 32'd1);
      tick();
      drive(0, 0, 0, 0, 0);
      repeat (4) tick();
      drive(0, 1, 0, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0);
      repeat (3) tick();
      chk("lu_drain_c12", {30'd0, state}, 32'd2);
      tick();
      chk("lu_halted", {30'd0, state}, 32'd3);
      chk("lu_retire", {16'd0, retire_cnt}, 32'd6);
      chk("lu_cycle", {16'd0, cycle_cnt}, 32'd12);

      // Redirect priority, drain abort, long run for 4-bit saturation
      #3 rst = 1'b1;
      #3 rst = 1'b0;
      tick();
      drive(1, 0, 0, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0);
      repeat (3) begin
         drive(0, 0, 1, 0, 0);
         tick();
         drive(0, 0, 0, 0, 0);
         tick();
      end
      drive(0, 1, 1, 1, 0);
      #1;
      chk("br_pc_wr", {31'd0, pc_wr}, 32'd1);
      chk("br_flush", {31'd0, if_id_flush}, 32'd1);
      chk("br_bubble", {31'd0, id_ex_bubble}, 32'd1);
      chk("br_if_id_wr", {31'd0, if_id_wr}, 32'd1);
      tick();
      chk("br_stay_run", {30'd0, state}, 32'd1);
      drive(0, 1, 0, 0, 1);
      #1;
      chk("jmp_pc_wr", {31'd0, pc_wr}, 32'd1);
      chk("jmp_bubble", {31'd0, id_ex_bubble}, 32'd0);
      tick();
      chk("jmp_stay_run", {30'd0, state}, 32'd1);
      drive(0, 0, 0, 0, 0);
      tick();
      drive(0, 1, 0, 0, 0);
      tick();
      chk("abort_drain", {30'd0, state}, 32'd2);
      drive(0, 0, 0, 1, 0);
      #1;
      chk("abort_pc_wr", {31'd0, pc_wr}, 32'd1);
      tick();
      chk("abort_run", {30'd0, state}, 32'd1);
      drive(0, 0, 0, 0, 0);
      repeat (20) tick();
      drive(0, 1, 0, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0);
      run_to_halt("abort_halted");
      chk("sat_cycle4", {28'd0, cycle_cnt4}, 32'd15);
`ifdef STALL_STATS_EN
      chk("stall3", {16'd0, stall_cnt}, 32'd3);
`endif
      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
